// File: rtl/l2_fill_assembler.sv
// Assembles byte-reversed 32-bit memory beats into one L2 fill line; framing errors flagged.
// Latency: line_valid rises the cycle after the final beat is accepted.
// Backpressure: beat_ready drops while the single line buffer is full; no path from line_ready to beat_ready.
module l2_fill_assembler #(
    parameter int WORD_COUNT  = 16,
    parameter bit SWAP_ENABLE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     beat_valid,
    output logic                     beat_ready,
    input  logic [31:0]              beat_data,
    input  logic                     beat_last,
    output logic                     line_valid,
    input  logic                     line_ready,
    output logic [WORD_COUNT*32-1:0] line_data,
    output logic                     line_error
);

    localparam int CW = $clog2(WORD_COUNT);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [WORD_COUNT*32-1:0] line_q, line_d;
    logic                    err_q, err_d;

    logic [31:0] word_in;
    logic        last_slot;
    int          slot;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        line_d     = line_q;
        err_d      = err_q;
        word_in    = SWAP_ENABLE ? {beat_data[7:0], beat_data[15:8], beat_data[23:16], beat_data[31:24]}
                                 : beat_data;
        last_slot  = (count_q == CW'(WORD_COUNT - 1));
        slot       = WORD_COUNT - 1 - int'(count_q);
        // reset_n gates ready directly so no beat handshake can appear during reset
        beat_ready = reset_n && (state_q == ST_COLLECT);
        line_valid = (state_q == ST_FULL);

        case (state_q)
            ST_COLLECT: begin
                if (beat_valid && beat_ready) begin
                    line_d[slot*32 +: 32] = word_in;
                    if (beat_last || last_slot) begin
                        state_d = ST_FULL;
                        err_d   = (beat_last != last_slot);
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (line_ready) begin
                    state_d = ST_COLLECT;
                    count_d = '0;
                    line_d  = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_COLLECT;
            count_q <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            line_q  <= line_d;
            err_q   <= err_d;
        end
    end

    assign line_data  = line_q;
    assign line_error = err_q;

endmodule

// File: tb/tb_l2_fill_assembler.sv
// Bench for l2_fill_assembler: table of bursts plus hand sequences, lines checked via a scoreboard.
module tb_l2_fill_assembler;

    localparam int WC = 16;
    localparam int LW = WC * 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          beat_valid, beat_ready, beat_last;
    logic [31:0]   beat_data;
    logic          line_valid, line_ready, line_error;
    logic [LW-1:0] line_data;

    logic          ns_beat_valid, ns_beat_ready, ns_beat_last;
    logic [31:0]   ns_beat_data;
    logic          ns_line_valid, ns_line_ready, ns_line_error;
    logic [LW-1:0] ns_line_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_fill_assembler #(.WORD_COUNT(WC), .SWAP_ENABLE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_data(beat_data), .beat_last(beat_last),
        .line_valid(line_valid), .line_ready(line_ready),
        .line_data(line_data), .line_error(line_error)
    );

    l2_fill_assembler #(.WORD_COUNT(WC), .SWAP_ENABLE(1'b0)) u_ns (
        .clk(clk), .reset_n(reset_n),
        .beat_valid(ns_beat_valid), .beat_ready(ns_beat_ready),
        .beat_data(ns_beat_data), .beat_last(ns_beat_last),
        .line_valid(ns_line_valid), .line_ready(ns_line_ready),
        .line_data(ns_line_data), .line_error(ns_line_error)
    );

    typedef struct {
        logic [LW-1:0] line;
        logic          err;
        logic          has_w0;
        logic [31:0]   w0;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        int          nbeats;
        logic [31:0] base;
        int          last_idx;
        logic        exp_err;
        logic [31:0] exp_w0;
    } vec_t;

    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line: slot k holds swap(base+k) for k < nbeats, remaining slots zero.
    task automatic push_line(input logic [31:0] base, input int nbeats, input logic err,
                             input logic has_w0, input logic [31:0] w0);
        exp_t e;
        e.line = '0;
        for (int k = 0; k < nbeats; k++)
            e.line[(WC-1-k)*32 +: 32] = swap32(base + 32'(k));
        e.err    = err;
        e.has_w0 = has_w0;
        e.w0     = w0;
        sb_q.push_back(e);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int w;
        w = 0;
        beat_valid = 1'b1;
        beat_data  = d;
        beat_last  = l;
        @(negedge clk);
        while (!beat_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!beat_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: beat_ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
    endtask

    task automatic send_burst(input logic [31:0] base, input int n, input int last_idx);
        for (int k = 0; k < n; k++)
            send_beat(base + 32'(k), (k == last_idx));
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d lines outstanding, required 0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every consumed line is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && line_valid && line_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_line: got line %0h with none expected", line_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("line_data", line_data, e.line);
                    chk("line_error", LW'(line_error), LW'(e.err));
                    if (e.has_w0)
                        chk("word0", LW'(line_data[LW-1 -: 32]), LW'(e.w0));
                end
            end
        end
    end

    vec_t vecs[5];

    initial begin
        logic [LW-1:0] exp_line;

        vecs[0] = '{16, 32'h0011_2233, 15, 1'b0, 32'h3322_1100};
        vecs[1] = '{4,  32'hA0B0_C0D0, 3,  1'b1, 32'hD0C0_B0A0};
        vecs[2] = '{16, 32'h0102_0304, 15, 1'b0, 32'h0403_0201};
        vecs[3] = '{1,  32'hCAFE_F00D, 0,  1'b1, 32'h0DF0_FECA};
        vecs[4] = '{9,  32'h1020_3040, 8,  1'b1, 32'h4030_2010};

        reset_n       = 1'b0;
        beat_valid    = 1'b0;
        beat_data     = '0;
        beat_last     = 1'b0;
        line_ready    = 1'b1;
        ns_beat_valid = 1'b0;
        ns_beat_data  = '0;
        ns_beat_last  = 1'b0;
        ns_line_ready = 1'b0;

        @(negedge clk);
        chk("rst_beat_ready", LW'(beat_ready), '0);
        chk("rst_line_valid", LW'(line_valid), '0);
        chk("rst_line_error", LW'(line_error), '0);
        chk("rst_line_data", line_data, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table of single-line bursts, including normal, short and one-beat lines.
        for (int i = 0; i < 5; i++) begin
            push_line(vecs[i].base, vecs[i].nbeats, vecs[i].exp_err, 1'b1, vecs[i].exp_w0);
            send_burst(vecs[i].base, vecs[i].nbeats, vecs[i].last_idx);
            @(negedge clk);
            chk("line_latency", LW'(line_valid), LW'(1));
            wait_drain();
        end

        // Backpressure: line held 20 cycles while a beat waits on the input.
        line_ready = 1'b0;
        exp_line = '0;
        for (int k = 0; k < WC; k++)
            exp_line[(WC-1-k)*32 +: 32] = swap32(32'h55AA_0000 + 32'(k));
        push_line(32'h55AA_0000, WC, 1'b0, 1'b0, '0);
        push_line(32'h7700_0000, WC, 1'b0, 1'b1, 32'h0000_0077);
        send_burst(32'h55AA_0000, WC, WC - 1);
        beat_valid = 1'b1;
        beat_data  = 32'h7700_0000;
        beat_last  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_beat_ready", LW'(beat_ready), '0);
            chk("bp_line_valid", LW'(line_valid), LW'(1));
            chk("bp_line_data", line_data, exp_line);
        end
        @(posedge clk);
        #1;
        line_ready = 1'b1;
        @(negedge clk);
        chk("consume_cycle_beat_ready", LW'(beat_ready), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("next_beat_ready", LW'(beat_ready), LW'(1));
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        for (int k = 1; k < WC; k++)
            send_beat(32'h7700_0000 + 32'(k), (k == WC - 1));
        wait_drain();

        // Long burst: 16 beats without last, then a lone last beat.
        push_line(32'h600D_0000, WC, 1'b1, 1'b0, '0);
        push_line(32'hF00D_BEEF, 1, 1'b1, 1'b1, 32'hEFBE_0DF0);
        send_burst(32'h600D_0000, WC, -1);
        send_beat(32'hF00D_BEEF, 1'b1);
        wait_drain();

        // Reset mid-line discards the partial line.
        send_burst(32'hEEEE_0000, 7, -1);
        reset_n    = 1'b0;
        beat_valid = 1'b1;
        beat_data  = 32'hEEEE_0007;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("midrst_beat_ready", LW'(beat_ready), '0);
            chk("midrst_line_valid", LW'(line_valid), '0);
            chk("midrst_line_data", line_data, '0);
        end
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        reset_n    = 1'b1;
        push_line(32'h1234_0000, WC, 1'b0, 1'b0, '0);
        send_burst(32'h1234_0000, WC, WC - 1);
        wait_drain();

        // Swap disabled instance.
        ns_beat_valid = 1'b1;
        ns_beat_data  = 32'hDEAD_BEEF;
        ns_beat_last  = 1'b1;
        @(negedge clk);
        chk("ns_beat_ready", LW'(ns_beat_ready), LW'(1));
        @(posedge clk);
        #1;
        ns_beat_valid = 1'b0;
        ns_beat_last  = 1'b0;
        @(negedge clk);
        chk("ns_line_valid", LW'(ns_line_valid), LW'(1));
        chk("ns_word0", LW'(ns_line_data[LW-1 -: 32]), LW'(32'hDEAD_BEEF));
        chk("ns_word1", LW'(ns_line_data[LW-33 -: 32]), '0);
        chk("ns_line_error", LW'(ns_line_error), LW'(1));
        @(posedge clk);
        #1;
        ns_line_ready = 1'b1;
        @(posedge clk);
        #1;
        ns_line_ready = 1'b0;
        @(negedge clk);
        chk("ns_after_valid", LW'(ns_line_valid), '0);
        chk("ns_after_data", ns_line_data, '0);

        chk("sb_empty", LW'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
